// File: rtl/n2t_reduce_pkg.sv
// Shared definitions for the N-way reduction pipeline: mode encodings,
// group size, and the per-mode identity/combine helpers used everywhere.
package n2t_reduce_pkg;

    typedef enum logic [1:0] {
        MODE_OR   = 2'b00,
        MODE_AND  = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam int GROUP = 8;

    function automatic logic mode_identity(input logic [1:0] mode);
        return (mode == MODE_AND);
    endfunction

    // Reserved encoding falls through to OR.
    function automatic logic mode_op(input logic [1:0] mode, input logic a, input logic b);
        case (mode)
            MODE_AND: return a & b;
            MODE_XOR: return a ^ b;
            default:  return a | b;
        endcase
    endfunction

endpackage

// File: rtl/reduce_nway_reduce8.sv
// Combinational reduction of one 8-bit group with a selectable operator.
module reduce8
    import n2t_reduce_pkg::*;
(
    input  logic [GROUP-1:0] data_i,
    input  logic [1:0]       mode_i,
    output logic             result_o
);

    always_comb begin
        result_o = mode_identity(mode_i);
        for (int i = 0; i < GROUP; i++) begin
            result_o = mode_op(mode_i, result_o, data_i[i]);
        end
    end

endmodule

// File: rtl/reduce_nway.sv
// Two-stage valid/ready pipeline reducing a WIDTH-bit vector to one bit,
// with a side accumulator folding in results of flagged beats.
module reduce_nway
    import n2t_reduce_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_acc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_clear,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             acc
);

    localparam int NGROUPS = (WIDTH + GROUP - 1) / GROUP;
    localparam int PWIDTH  = NGROUPS * GROUP;

    logic [PWIDTH-1:0]  padded;
    logic [NGROUPS-1:0] part;

    logic               s1_valid_q, s1_valid_d;
    logic [NGROUPS-1:0] s1_part_q, s1_part_d;
    logic [1:0]         s1_mode_q, s1_mode_d;
    logic               s1_acc_q, s1_acc_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               acc_q, acc_d;

    logic s2_load, s1_load, accept, combined;

    // Unused top bits take the identity so they never change the result.
    always_comb begin
        padded              = {PWIDTH{mode_identity(in_mode)}};
        padded[WIDTH-1:0]   = in_data;
    end

    for (genvar g = 0; g < NGROUPS; g++) begin : g_group
        reduce8 u_reduce8 (
            .data_i   (padded[g*GROUP +: GROUP]),
            .mode_i   (in_mode),
            .result_o (part[g])
        );
    end

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        combined = mode_identity(s1_mode_q);
        for (int i = 0; i < NGROUPS; i++) begin
            combined = mode_op(s1_mode_q, combined, s1_part_q[i]);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_part_d   = s1_part_q;
        s1_mode_d   = s1_mode_q;
        s1_acc_d    = s1_acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_clear ? mode_identity(in_mode) : acc_q;

        if (s1_load) begin
            s1_valid_d = accept;
            s1_part_d  = part;
            s1_mode_d  = in_mode;
            s1_acc_d   = in_acc;
        end

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = combined;
            end
        end

        // Clear happens first, so a coincident flagged beat folds onto the identity.
        if (s2_load && s1_valid_q && s1_acc_q) begin
            acc_d = mode_op(s1_mode_q, acc_d, combined);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_part_q   <= '0;
            s1_mode_q   <= 2'b00;
            s1_acc_q    <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_part_q   <= s1_part_d;
            s1_mode_q   <= s1_mode_d;
            s1_acc_q    <= s1_acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_reduce_nway.sv
// Bench for reduce_nway: directed beats with literal expectations plus a
// negedge monitor comparing the output stream and accumulator to a model.
module tb_reduce_nway;

    localparam int W   = 16;
    localparam int W12 = 12;
    localparam logic [1:0] M_OR = 2'b00, M_AND = 2'b01, M_XOR = 2'b10, M_RSV = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         in_acc, in_valid, in_ready, acc_clear;
    logic         out, out_valid, out_ready, acc;

    logic [W12-1:0] in_data_12;
    logic [1:0]     in_mode_12;
    logic           in_acc_12, in_valid_12, in_ready_12, acc_clear_12;
    logic           out_12, out_valid_12, out_ready_12, acc_12;

    reduce_nway #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode),
        .in_acc(in_acc), .in_valid(in_valid), .in_ready(in_ready),
        .acc_clear(acc_clear), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .acc(acc)
    );

    reduce_nway #(.WIDTH(W12)) dut12 (
        .clk(clk), .reset(reset), .in_data(in_data_12), .in_mode(in_mode_12),
        .in_acc(in_acc_12), .in_valid(in_valid_12), .in_ready(in_ready_12),
        .acc_clear(acc_clear_12), .out(out_12), .out_valid(out_valid_12),
        .out_ready(out_ready_12), .acc(acc_12)
    );

    int n_vec = 0;
    int n_fail = 0;
    int n_consumed = 0;

    typedef struct packed {
        logic       res;
        logic [1:0] mode;
        logic       accf;
    } beat_t;

    beat_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic model_reduce(input logic [W-1:0] d, input logic [1:0] m);
        case (m)
            M_AND:   return &d;
            M_XOR:   return ^d;
            default: return |d;
        endcase
    endfunction

    function automatic logic model_op(input logic [1:0] m, input logic a, input logic b);
        case (m)
            M_AND:   return a & b;
            M_XOR:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic model_id(input logic [1:0] m);
        return (m == M_AND) ? 1'b1 : 1'b0;
    endfunction

    // Monitor: inputs change just after posedge, so negedge sees stable values.
    logic       prev_reset = 1'b1;
    logic       prev_clear = 1'b0;
    logic [1:0] prev_mode = 2'b00;
    logic       prev_out_valid = 1'b0;
    logic       prev_consumed = 1'b0;
    logic       acc_model = 1'b0;
    beat_t      mon_beat;

    always @(negedge clk) begin
        if (prev_reset) begin
            exp_q.delete();
            acc_model = 1'b0;
        end else begin
            if (prev_clear) acc_model = model_id(prev_mode);
            if (out_valid && (!prev_out_valid || prev_consumed) && exp_q.size() > 0) begin
                mon_beat = exp_q[0];
                if (mon_beat.accf) acc_model = model_op(mon_beat.mode, acc_model, mon_beat.res);
            end
        end
        if (out_valid && exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL out_valid_no_beat: got out_valid=1 expected no pending beat at %0t", $time);
        end
        if (out_valid && exp_q.size() > 0) check("out_stream", out, exp_q[0].res);
        check("acc_track", acc, acc_model);
        if (out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_consumed++;
        end
        if (in_valid && in_ready) begin
            mon_beat.res  = model_reduce(in_data, in_mode);
            mon_beat.mode = in_mode;
            mon_beat.accf = in_acc;
            exp_q.push_back(mon_beat);
        end
        prev_reset     = reset;
        prev_clear     = acc_clear;
        prev_mode      = in_mode;
        prev_out_valid = out_valid;
        prev_consumed  = out_valid && out_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and return just after the edge that accepts it.
    task automatic send(input logic [W-1:0] d, input logic [1:0] m, input logic a);
        int k;
        in_data  = d;
        in_mode  = m;
        in_acc   = a;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_acc   = 1'b0;
    endtask

    task automatic beat_lat(input logic [W-1:0] d, input logic [1:0] m, input logic e, input string name);
        step();
        send(d, m, 1'b0);
        @(negedge clk);
        check({name, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_out"}, out, e);
    endtask

    task automatic beat12(input logic [W12-1:0] d, input logic [1:0] m, input logic e, input string name);
        int k;
        step();
        in_data_12  = d;
        in_mode_12  = m;
        in_valid_12 = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready_12 && k < 100) begin
            k++;
            @(negedge clk);
        end
        check({name, "_ready"}, in_ready_12, 1'b1);
        step();
        in_valid_12 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, "_valid"}, out_valid_12, 1'b1);
        check({name, "_out"}, out_12, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int k;
        reset = 1'b1;
        in_data = '0; in_mode = M_OR; in_acc = 1'b0; in_valid = 1'b0;
        acc_clear = 1'b0; out_ready = 1'b1;
        in_data_12 = '0; in_mode_12 = M_OR; in_acc_12 = 1'b0; in_valid_12 = 1'b0;
        acc_clear_12 = 1'b0; out_ready_12 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 1'b0);
        check("rst_acc", acc, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);

        beat_lat(16'h0000, M_OR,  1'b0, "or_0000");
        beat_lat(16'h0100, M_OR,  1'b1, "or_0100");
        beat_lat(16'hFFFF, M_AND, 1'b1, "and_ffff");
        beat_lat(16'hFFFE, M_AND, 1'b0, "and_fffe");
        beat_lat(16'h0007, M_XOR, 1'b1, "xor_0007");
        beat_lat(16'h0101, M_XOR, 1'b0, "xor_0101");
        beat_lat(16'h8000, M_RSV, 1'b1, "rsv_8000");
        beat_lat(16'h7FFF, M_AND, 1'b0, "and_7fff");

        beat12(12'hFFF, M_AND, 1'b1, "w12_and_fff");
        beat12(12'h000, M_OR,  1'b0, "w12_or_000");
        beat12(12'h800, M_XOR, 1'b1, "w12_xor_800");

        // Backpressure: two beats fill the pipe, the third must wait.
        step();
        out_ready = 1'b0;
        n0 = n_consumed;
        send(16'h0100, M_OR, 1'b0);
        send(16'h0000, M_OR, 1'b0);
        in_data = 16'h0001; in_mode = M_OR; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_out_valid_hold", out_valid, 1'b1);
            check("bp_out_hold", out, 1'b1);
        end
        step();
        out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("bp_third_accept", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_consumed_count", n_consumed - n0, 3);

        // Accumulator
        step();
        acc_clear = 1'b1; in_mode = M_OR;
        step();
        acc_clear = 1'b0;
        @(negedge clk);
        check("acc_clear_or", acc, 1'b0);
        step(); send(16'h0000, M_OR, 1'b1);
        repeat (3) @(negedge clk);
        check("acc_or_0a", acc, 1'b0);
        step(); send(16'h0000, M_OR, 1'b1);
        repeat (3) @(negedge clk);
        check("acc_or_0b", acc, 1'b0);
        step(); send(16'h0010, M_OR, 1'b1);
        repeat (3) @(negedge clk);
        check("acc_or_1", acc, 1'b1);

        step(); send(16'hFFFE, M_AND, 1'b1);
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        @(negedge clk);
        check("acc_and_clear_res0", acc, 1'b0);
        step(); send(16'hFFFF, M_AND, 1'b1);
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        @(negedge clk);
        check("acc_and_clear_res1", acc, 1'b1);

        // Reset with both stages occupied.
        step();
        out_ready = 1'b0;
        send(16'h0001, M_OR, 1'b1);
        send(16'h0001, M_OR, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_before", out, 1'b1);
        check("mid_rst_in_ready", in_ready, 1'b0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out", out, 1'b0);
        check("mid_rst_acc", acc, 1'b0);
        check("mid_rst_in_ready_after", in_ready, 1'b1);
        beat_lat(16'h0001, M_OR, 1'b1, "post_rst_or");

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/reduce_nway.md
REDUCE_NWAY -- requirements
Module: reduce_nway

Interface
REQ-001 Parameter WIDTH, default 16, input vector width; any value >= 1 SHALL be legal.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_data  input  WIDTH  vector to reduce.
REQ-005 in_mode  input  2  reduction op: 00 OR, 01 AND, 10 XOR, 11 reserved (SHALL behave as OR).
REQ-006 in_acc  input  1  beat participates in accumulator update.
REQ-007 in_valid  input  1  beat offered.
REQ-008 in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
REQ-009 acc_clear  input  1  load accumulator with identity of in_mode.
REQ-010 out  output  1  reduced result of the current output beat.
REQ-011 out_valid  output  1  out holds a valid result.
REQ-012 out_ready  input  1  consumer takes the result when out_valid && out_ready.
REQ-013 acc  output  1  running accumulated result.

Function
REQ-014 Input SHALL be split into ceil(WIDTH/8) groups of 8 bits, bit 0 in group 0; missing top bits SHALL be padded with the mode identity (0 for OR/XOR, 1 for AND).
REQ-015 Stage 1 register SHALL hold one partial reduction per group plus mode and acc flag and a valid bit; stage 2 (output register) SHALL combine partials with the same op into out.
REQ-016 Latency: beat accepted at edge N SHALL appear with out_valid=1 in the cycle after edge N+1 when not stalled; throughput one beat per cycle.
REQ-017 Stage 2 SHALL load when !out_valid || out_ready; stage 1 SHALL load when empty or stage 2 loads; in_ready SHALL equal (!s1_valid || stage-2-loads) && !reset, combinational.
REQ-018 While out_valid && !out_ready, out and out_valid SHALL hold stable; beats SHALL never be dropped, duplicated or reordered.
REQ-019 On the edge a beat with acc flag set loads stage 2, acc SHALL become acc OP out_result using that beat's mode.
REQ-020 acc_clear SHALL load identity(in_mode); if a flagged beat loads stage 2 the same edge, acc SHALL become identity OP result (clear first, then apply).
REQ-021 acc_clear SHALL not affect the pipeline or handshake.

Reset
REQ-022 On reset: s1_valid=0, out_valid=0, out=0, acc=0, in_ready=0 during reset; in-flight beats SHALL be discarded.
REQ-023 First cycle after reset deasserts: in_ready=1, out_valid=0.

Structure
REQ-024 Package n2t_reduce_pkg SHALL hold mode encodings, GROUP=8 constant, and an identity-of-mode function.
REQ-025 One sub-module reduce8 (8-bit combinational mode-selectable reduction) SHALL be instantiated per group; stage 2 combination SHALL reuse the same op selection.

Verification (WIDTH=16 unless stated)
REQ-026 OR: 16'h0000 -> out=0; 16'h0100 -> out=1; each out_valid two edges after acceptance.
REQ-027 AND 16'hFFFF -> 1, AND 16'hFFFE -> 0, XOR 16'h0007 -> 1, mode 11 with 16'h8000 -> 1; WIDTH=12 AND 12'hFFF -> 1.
REQ-028 Backpressure: out_ready=0, offer beats OR 1, OR 0, OR 1 back-to-back -> in_ready drops after 2 accepted, out=1 held; raise out_ready -> outputs 1,0,1 in order, exactly once each.
REQ-029 Accumulate: acc_clear with mode OR, then OR beats 0,0,16'h0010 with in_acc=1 -> acc 0,0,1; AND clear coincident with flagged AND result 0 -> acc=0.
REQ-030 Reset with s1 and output stage both valid -> next cycle out_valid=0, out=0, acc=0; following beat 16'h0001 OR -> out=1 with normal latency.
